// File: rtl/if_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch stage with a small decoupling queue in front of decode.
// PCF addresses an asynchronous-read instruction memory; each accepted fetch
// stores {instruction, PC, PC+4} into a DEPTH-entry FIFO.  Decode pulls from
// the head with a valid/ready handshake.  A taken branch/jump from EX
// (PCSrcE) redirects PCF and flushes the whole queue.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   PCTargetE   redirect target from EX (low two bits ignored)
//   PCSrcE      redirect request
//   imem_addr   byte address to instruction memory, = PCF[ADDR_BITS-1:0]
//   imem_rdata  instruction at imem_addr, same cycle
//   InstrD      head-entry instruction (0 when empty)
//   PCD         head-entry PC (0 when empty)
//   PCPlus4D    head-entry PC+4 (0 when empty)
//   validD      head entry present
//   readyD      decode accepts the head entry this cycle
//   PCF         current fetch PC
//   count       occupied entries, 0..DEPTH
// ----------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_BITS  = 12,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        PCTargetE,
    input  logic                         PCSrcE,
    output logic [ADDR_BITS-1:0]         imem_addr,
    input  logic [DATA_WIDTH-1:0]        imem_rdata,
    output logic [DATA_WIDTH-1:0]        InstrD,
    output logic [DATA_WIDTH-1:0]        PCD,
    output logic [DATA_WIDTH-1:0]        PCPlus4D,
    output logic                         validD,
    input  logic                         readyD,
    output logic [DATA_WIDTH-1:0]        PCF,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_pcf;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_not_empty;
    logic [DATA_WIDTH-1:0] w_pcf_plus4;
    logic [DATA_WIDTH-1:0] w_redirect_pc;
    logic                  w_unused_target_lsbs;

    logic [DATA_WIDTH-1:0] w_entry_instr [DEPTH];
    logic [DATA_WIDTH-1:0] w_entry_pc    [DEPTH];
    logic [DATA_WIDTH-1:0] w_entry_pc4   [DEPTH];

    assign w_not_empty   = (r_count != '0);
    assign w_pop         = w_not_empty & readyD;
    // A pop in the same cycle frees the slot we are about to write, so a
    // full queue can still accept a fetch while decode is draining it.
    assign w_push        = ~PCSrcE & ((r_count != FULL_COUNT) | w_pop);
    assign w_pcf_plus4   = r_pcf + DATA_WIDTH'(4);
    assign w_redirect_pc = {PCTargetE[DATA_WIDTH-1:2], 2'b00};
    // Target is word-aligned by construction; the low bits are dropped.
    assign w_unused_target_lsbs = ^PCTargetE[1:0];

    // PC, pointers and occupancy.  Redirect wins over push and pop: the
    // queue is flushed, including any entry decode is taking this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcf    <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (PCSrcE) begin
            r_pcf    <= w_redirect_pc;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pcf    <= w_pcf_plus4;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Queue storage.  Entries need no reset: outputs are gated by count,
    // so stale contents are never visible.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] r_instr;
            logic [DATA_WIDTH-1:0] r_pc;
            logic [DATA_WIDTH-1:0] r_pc4;

            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_instr <= imem_rdata;
                    r_pc    <= r_pcf;
                    r_pc4   <= w_pcf_plus4;
                end
            end

            assign w_entry_instr[gi] = r_instr;
            assign w_entry_pc[gi]    = r_pc;
            assign w_entry_pc4[gi]   = r_pc4;
        end
    endgenerate

    // Head entry is presented combinationally, so a freshly pushed entry is
    // visible in the very next cycle with no bubble.
    assign validD    = w_not_empty;
    assign InstrD    = w_not_empty ? w_entry_instr[r_rd_ptr] : '0;
    assign PCD       = w_not_empty ? w_entry_pc[r_rd_ptr]    : '0;
    assign PCPlus4D  = w_not_empty ? w_entry_pc4[r_rd_ptr]   : '0;
    assign imem_addr = r_pcf[ADDR_BITS-1:0];
    assign PCF       = r_pcf;
    assign count     = r_count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_queue
//
// Two instances: dut0 (RESET_PC=0) is driven by a directed vector table,
// hand-written reset sequences and random traffic, all checked against a
// queue-based reference model.  dut1 (RESET_PC=0xFFFFFFF8) streams with
// readyD tied high to exercise PC wrap-around.
// ----------------------------------------------------------------------------
module tb_if_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        readyD = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;

    logic [11:0] imem_addr0, imem_addr1;
    logic [31:0] imem_rdata0, imem_rdata1;
    logic [31:0] InstrD0, PCD0, PCPlus4D0, PCF0;
    logic [31:0] InstrD1, PCD1, PCPlus4D1, PCF1;
    logic        validD0, validD1;
    logic [2:0]  count0, count1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_f(input logic [11:0] a);
        return {8'hA5, a, a ^ 12'h3C3};
    endfunction

    assign imem_rdata0 = imem_f(imem_addr0);
    assign imem_rdata1 = imem_f(imem_addr1);

    if_fetch_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_BITS(12), .RESET_PC(32'h0)) dut0 (
        .clk(clk), .rst(rst), .PCTargetE(PCTargetE), .PCSrcE(PCSrcE),
        .imem_addr(imem_addr0), .imem_rdata(imem_rdata0),
        .InstrD(InstrD0), .PCD(PCD0), .PCPlus4D(PCPlus4D0), .validD(validD0),
        .readyD(readyD), .PCF(PCF0), .count(count0)
    );

    if_fetch_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_BITS(12), .RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst(rst), .PCTargetE(32'h0), .PCSrcE(1'b0),
        .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
        .InstrD(InstrD1), .PCD(PCD1), .PCPlus4D(PCPlus4D1), .validD(validD1),
        .readyD(1'b1), .PCF(PCF1), .count(count1)
    );

    // ---------------- reference model (dut0) ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpcf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpcf = 32'h0;
    endtask

    task automatic model_check();
        chk("m_count", {29'b0, count0}, mq.size());
        chk("m_valid", {31'b0, validD0}, {31'b0, mq.size() != 0});
        chk("m_pcf", PCF0, mpcf);
        chk("m_imem_addr", {20'b0, imem_addr0}, {20'b0, mpcf[11:0]});
        if (mq.size() != 0) begin
            chk("m_pcd", PCD0, mq[0].pc);
            chk("m_pcplus4d", PCPlus4D0, mq[0].pc + 32'd4);
            chk("m_instrd", InstrD0, mq[0].instr);
        end else begin
            chk("m_pcd_empty", PCD0, 32'h0);
            chk("m_pcplus4d_empty", PCPlus4D0, 32'h0);
            chk("m_instrd_empty", InstrD0, 32'h0);
        end
    endtask

    // Applies the rules for one rising edge using the inputs held this cycle.
    task automatic model_update();
        if (PCSrcE) begin
            mq.delete();
            mpcf = PCTargetE & ~32'h3;
        end else begin
            if (mq.size() != 0 && readyD) void'(mq.pop_front());
            if (mq.size() < DEPTH) begin
                mq.push_back('{instr: imem_f(mpcf[11:0]), pc: mpcf});
                mpcf = mpcf + 32'd4;
            end
        end
    endtask

    // Inputs change just after posedge; outputs are sampled at negedge.
    task automatic apply(input logic r, input logic s, input logic [31:0] t);
        readyD    = r;
        PCSrcE    = s;
        PCTargetE = t;
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rdy;
        logic        src;
        logic [31:0] tgt;
        int          cnt;
        logic [31:0] pcf;
        logic        vld;
        logic [31:0] pcd;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [31:0] e_pcd;
        logic [31:0] e_pcf;

        tbl[0]  = '{1'b1, 1'b0, 32'h0,   0, 32'h000, 1'b0, 32'h000};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,   1, 32'h004, 1'b1, 32'h000};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,   1, 32'h008, 1'b1, 32'h004};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   1, 32'h00C, 1'b1, 32'h008};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   2, 32'h010, 1'b1, 32'h008};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   3, 32'h014, 1'b1, 32'h008};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,   4, 32'h018, 1'b1, 32'h008};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,   4, 32'h018, 1'b1, 32'h008};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,   4, 32'h018, 1'b1, 32'h008};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,   4, 32'h01C, 1'b1, 32'h00C};
        tbl[10] = '{1'b1, 1'b0, 32'h0,   4, 32'h020, 1'b1, 32'h010};
        tbl[11] = '{1'b1, 1'b1, 32'h203, 4, 32'h024, 1'b1, 32'h014};
        tbl[12] = '{1'b1, 1'b0, 32'h0,   0, 32'h200, 1'b0, 32'h000};
        tbl[13] = '{1'b1, 1'b0, 32'h0,   1, 32'h204, 1'b1, 32'h200};

        // Initial reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pcf0", PCF0, 32'h0);
        chk("rst_valid0", {31'b0, validD0}, 32'h0);
        chk("rst_count0", {29'b0, count0}, 32'h0);
        chk("rst_pcf1", PCF1, 32'hFFFF_FFF8);
        rst = 1'b1;
        model_reset();

        // Stream, back-pressure, full push+pop, redirect while full
        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].rdy, tbl[i].src, tbl[i].tgt);
            chk($sformatf("tbl%0d_count", i), {29'b0, count0}, tbl[i].cnt);
            chk($sformatf("tbl%0d_pcf", i), PCF0, tbl[i].pcf);
            chk($sformatf("tbl%0d_valid", i), {31'b0, validD0}, {31'b0, tbl[i].vld});
            chk($sformatf("tbl%0d_pcd", i), PCD0, tbl[i].pcd);
            chk($sformatf("tbl%0d_pcplus4", i), PCPlus4D0, tbl[i].vld ? tbl[i].pcd + 32'd4 : 32'h0);
            chk($sformatf("tbl%0d_instr", i), InstrD0, tbl[i].vld ? imem_f(tbl[i].pcd[11:0]) : 32'h0);
            advance();
        end

        // Fill to 3 entries, then assert reset between clock edges
        apply(1'b0, 1'b0, 32'h0); advance();
        apply(1'b0, 1'b0, 32'h0); advance();
        readyD = 1'b0; PCSrcE = 1'b0;
        #2;
        chk("pre_rst_count", {29'b0, count0}, 32'd3);
        rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, validD0}, 32'h0);
        chk("async_rst_count", {29'b0, count0}, 32'h0);
        chk("async_rst_pcf", PCF0, 32'h0);
        chk("async_rst_pcd", PCD0, 32'h0);
        // Redirect requested while reset is held must be ignored
        PCSrcE = 1'b1; PCTargetE = 32'h400;
        @(posedge clk);
        #1;
        chk("rst_redirect_pcf", PCF0, 32'h0);
        chk("rst_redirect_count", {29'b0, count0}, 32'h0);
        PCSrcE = 1'b0; PCTargetE = 32'h0;
        rst = 1'b1;
        model_reset();

        // Wrap-around on dut1 while dut0 streams
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, 1'b0, 32'h0);
            e_pcf = 32'hFFFF_FFF8 + 32'(4 * k);
            e_pcd = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
            chk($sformatf("wrap%0d_pcf", k), PCF1, e_pcf);
            chk($sformatf("wrap%0d_valid", k), {31'b0, validD1}, (k == 0) ? 32'h0 : 32'h1);
            chk($sformatf("wrap%0d_pcd", k), PCD1, (k == 0) ? 32'h0 : e_pcd);
            chk($sformatf("wrap%0d_pcplus4", k), PCPlus4D1, (k == 0) ? 32'h0 : e_pcd + 32'd4);
            advance();
        end

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            apply($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 6, $urandom);
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
